// File: rtl/instr_sequencer_if.sv
// Memory bus between the instruction sequencer and main memory.
// Word-addressed request/acknowledge handshake: the master holds req/we/addr/wdata
// stable until it samples ack; read data is valid in the same cycle as ack.
interface instr_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator computer.
// Owns PC, IR, MBR and AC, talks to memory through instr_sequencer_if and
// drives the external combinational ALU, capturing its result into AC.
// Optional feature macro: SEQ_INDIRECT_EN enables AddI/JumpI/LoadI and the
// READ2 state; without it opcodes B, C, D are treated as illegal.
module instr_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.master mem,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] ir,
  output logic              instr_done,
  output logic              halted,
  output logic              illegal
);

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;
  localparam logic [3:0] OP_ADDI  = 4'hB;
  localparam logic [3:0] OP_JUMPI = 4'hC;
  localparam logic [3:0] OP_LOADI = 4'hD;

  localparam logic [3:0]        ALU_ADD = 4'b0000;
  localparam logic [3:0]        ALU_SUB = 4'b0001;
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    DECODE,
    READ,
`ifdef SEQ_INDIRECT_EN
    READ2,
`endif
    EXEC,
    WRITE,
    HALT
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mbr;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              retire;
  logic              bad_op;
  logic              skip_take;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;

  assign opcode  = ir[DATA_W-1 -: 4];
  assign ir_addr = ir[ADDR_W-1:0];

  assign alu_a  = ac;
  assign alu_b  = mbr;
  assign alu_op = (state == EXEC && opcode == OP_SUBT) ? ALU_SUB : ALU_ADD;

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = ac;

  // Skipcond condition: IR[11:10] picks AC<0, AC==0, AC>0 (signed) or never.
  always_comb begin
    skip_take = 1'b0;
    unique case (ir[11:10])
      2'b00:   skip_take = ac[DATA_W-1];
      2'b01:   skip_take = (ac == '0);
      2'b10:   skip_take = !ac[DATA_W-1] && (ac != '0);
      default: skip_take = 1'b0;
    endcase
  end

  // State register; a synchronous reset abandons any pending request.
  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= state_next;
  end

  // Next state, bus request and retire strobe, all decoded from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave one unassigned and infer a latch.
    state_next = state;
    retire     = 1'b0;
    bad_op     = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    addr       = pc;
    unique case (state)
      BOOT: state_next = FETCH;
      FETCH: begin
        req = 1'b1;
        if (mem.mem_ack) state_next = DECODE;
      end
      DECODE: begin
        unique case (opcode)
          OP_JUMP, OP_CLEAR, OP_SKIP: begin
            retire     = 1'b1;
            state_next = FETCH;
          end
          OP_HALT: begin
            retire     = 1'b1;
            state_next = HALT;
          end
          OP_STORE:                 state_next = WRITE;
          OP_LOAD, OP_ADD, OP_SUBT: state_next = READ;
`ifdef SEQ_INDIRECT_EN
          OP_ADDI, OP_JUMPI, OP_LOADI: state_next = READ;
`endif
          default: begin
            bad_op     = 1'b1;
            state_next = HALT;
          end
        endcase
      end
      READ: begin
        req  = 1'b1;
        addr = ir_addr;
        if (mem.mem_ack) begin
          if (opcode == OP_JUMPI) begin
            retire     = 1'b1;
            state_next = FETCH;
          end
`ifdef SEQ_INDIRECT_EN
          else if (opcode == OP_ADDI || opcode == OP_LOADI) begin
            state_next = READ2;
          end
`endif
          else begin
            state_next = EXEC;
          end
        end
      end
`ifdef SEQ_INDIRECT_EN
      READ2: begin
        req  = 1'b1;
        addr = mbr[ADDR_W-1:0];
        if (mem.mem_ack) state_next = EXEC;
      end
`endif
      EXEC: begin
        retire     = 1'b1;
        state_next = FETCH;
      end
      WRITE: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = ir_addr;
        if (mem.mem_ack) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // Architectural registers and status flags; updated only on accepted transfers or in decode/execute.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      pc         <= '0;
      ir         <= '0;
      mbr        <= '0;
      ac         <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      instr_done <= retire;
      unique case (state)
        FETCH: begin
          if (mem.mem_ack) begin
            ir <= mem.mem_rdata;
            pc <= pc + PC_ONE;
          end
        end
        DECODE: begin
          if (bad_op) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else if (opcode == OP_HALT) begin
            halted <= 1'b1;
          end else if (opcode == OP_JUMP) begin
            pc <= ir_addr;
          end else if (opcode == OP_CLEAR) begin
            ac <= '0;
          end else if (opcode == OP_SKIP && skip_take) begin
            pc <= pc + PC_ONE;
          end
        end
        READ: begin
          if (mem.mem_ack) begin
            mbr <= mem.mem_rdata;
            if (opcode == OP_JUMPI) pc <= mem.mem_rdata[ADDR_W-1:0];
          end
        end
`ifdef SEQ_INDIRECT_EN
        READ2: begin
          if (mem.mem_ack) mbr <= mem.mem_rdata;
        end
`endif
        EXEC: begin
          if (opcode == OP_LOAD || opcode == OP_LOADI) ac <= mbr;
          else                                         ac <= alu_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: small programs run to Halt from a
// table, plus hand-written sequences for latency, wait states and mid-transfer reset.
module tb_instr_sequencer;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ac, ir;
  logic              instr_done, halted, illegal;

  instr_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus.master),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .pc         (pc),
    .ac         (ac),
    .ir         (ir),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Memory model: words written by the initial block, ack after ack_delay wait cycles.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int                ack_delay = 0;
  logic              stray_ack = 1'b0;
  int                wait_cnt;
  int                done_cnt;
  int                wr_cnt;
  int                req_while_halted;
  logic [27:0]       wr_word;

  assign bus.mem_ack   = (bus.mem_req && wait_cnt >= ack_delay) || stray_ack;
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign alu_result    = (alu_op == 4'b0001) ? alu_a - alu_b : alu_a + alu_b;

  always @(posedge clk) begin
    if (reset || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else                                      wait_cnt <= wait_cnt + 1;
    if (reset) begin
      done_cnt         <= 0;
      wr_cnt           <= 0;
      wr_word          <= '0;
      req_while_halted <= 0;
    end else begin
      if (instr_done) done_cnt <= done_cnt + 1;
      if (halted && bus.mem_req) req_while_halted <= req_while_halted + 1;
      if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
        wr_cnt  <= wr_cnt + 1;
        wr_word <= {bus.mem_addr, bus.mem_wdata};
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
  endtask

  // Reset held across two edges, released at a falling edge: DUT is in BOOT on return.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, halted, 1);
  endtask

  // Cycles from the first request cycle until instr_done is seen (first request cycle = 1).
  task automatic cycles_to_done(input int budget, output int n);
    int c = 0;
    n = 0;
    while (!bus.mem_req && c < budget) begin
      @(negedge clk);
      c++;
    end
    n = 1;
    while (!instr_done && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] i0, i1, i2, i3, d5, d6, d8, dfe, dff;
    logic [15:0] ac_exp;
    logic [11:0] pc_exp;
    logic        ill_exp;
    int          done_exp;
    int          wr_exp;
    logic [27:0] wr_word_exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    int n;
    int nreq;
    int cyc;

    vecs[0]  = '{"load_add_store", 16'h1005, 16'h3006, 16'h2007, 16'h7000, 16'h0007, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0010, 12'h004, 1'b0, 4, 1, {12'h007, 16'h0010}};
    vecs[1]  = '{"subt_wrap",      16'hA000, 16'h4005, 16'h7000, 16'h0000, 16'h0001, 16'h0,    16'h0, 16'h0, 16'h0, 16'hFFFF, 12'h003, 1'b0, 3, 0, 28'h0};
    vecs[2]  = '{"add_wrap",       16'h1005, 16'h3006, 16'h7000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0000, 12'h003, 1'b0, 3, 0, 28'h0};
    vecs[3]  = '{"skip_neg",       16'h1005, 16'h8000, 16'hE000, 16'h7000, 16'hFFFF, 16'h0,    16'h0, 16'h0, 16'h0, 16'hFFFF, 12'h004, 1'b0, 3, 0, 28'h0};
    vecs[4]  = '{"skip_zero",      16'hA000, 16'h8400, 16'hE000, 16'h7000, 16'h0,    16'h0,    16'h0, 16'h0, 16'h0, 16'h0000, 12'h004, 1'b0, 3, 0, 28'h0};
    vecs[5]  = '{"noskip_pos",     16'hA000, 16'h8800, 16'h7000, 16'hE000, 16'h0,    16'h0,    16'h0, 16'h0, 16'h0, 16'h0000, 12'h003, 1'b0, 3, 0, 28'h0};
    vecs[6]  = '{"skip_never",     16'h1005, 16'h8C00, 16'h7000, 16'hE000, 16'hFFFF, 16'h0,    16'h0, 16'h0, 16'h0, 16'hFFFF, 12'h003, 1'b0, 3, 0, 28'h0};
    vecs[7]  = '{"illegal_e",      16'hE000, 16'h7000, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0, 16'h0, 16'h0, 16'h0000, 12'h001, 1'b1, 0, 0, 28'h0};
    vecs[8]  = '{"jump",           16'h9003, 16'hE000, 16'hE000, 16'h7000, 16'h0,    16'h0,    16'h0, 16'h0, 16'h0, 16'h0000, 12'h004, 1'b0, 2, 0, 28'h0};
    vecs[9]  = '{"skip_wrap",      16'h9FFE, 16'h7000, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0, 16'hA000, 16'h8400, 16'h0000, 12'h002, 1'b0, 4, 0, 28'h0};
    vecs[10] = '{"illegal_0",      16'h1005, 16'h0000, 16'h7000, 16'h0,    16'h8000, 16'h0,    16'h0, 16'h0, 16'h0, 16'h8000, 12'h002, 1'b1, 1, 0, 28'h0};
    vecs[11] = '{"illegal_6",      16'hA000, 16'h6000, 16'h7000, 16'h0,    16'h0,    16'h0,    16'h0, 16'h0, 16'h0, 16'h0000, 12'h002, 1'b1, 1, 0, 28'h0};
    vecs[12] = '{"halt_first",     16'h7000, 16'h1005, 16'h0,    16'h0,    16'h1111, 16'h0,    16'h0, 16'h0, 16'h0, 16'h0000, 12'h001, 1'b0, 1, 0, 28'h0};
`ifdef SEQ_INDIRECT_EN
    vecs[13] = '{"loadi",          16'hD005, 16'h7000, 16'h0,    16'h0,    16'h0008, 16'h0,    16'h1234, 16'h0, 16'h0, 16'h1234, 12'h002, 1'b0, 2, 0, 28'h0};
    vecs[14] = '{"addi",           16'h1006, 16'hB005, 16'h7000, 16'h0,    16'h0008, 16'h0002, 16'h1234, 16'h0, 16'h0, 16'h1236, 12'h003, 1'b0, 3, 0, 28'h0};
    vecs[15] = '{"jumpi",          16'hC005, 16'hE000, 16'hE000, 16'h7000, 16'h0003, 16'h0,    16'h0, 16'h0, 16'h0, 16'h0000, 12'h004, 1'b0, 2, 0, 28'h0};
`else
    vecs[13] = '{"loadi_off",      16'hD005, 16'h7000, 16'h0,    16'h0,    16'h0008, 16'h0,    16'h1234, 16'h0, 16'h0, 16'h0000, 12'h001, 1'b1, 0, 0, 28'h0};
    vecs[14] = '{"addi_off",       16'h1006, 16'hB005, 16'h7000, 16'h0,    16'h0008, 16'h0002, 16'h1234, 16'h0, 16'h0, 16'h0002, 12'h002, 1'b1, 1, 0, 28'h0};
    vecs[15] = '{"jumpi_off",      16'hC005, 16'hE000, 16'hE000, 16'h7000, 16'h0003, 16'h0,    16'h0, 16'h0, 16'h0, 16'h0000, 12'h001, 1'b1, 0, 0, 28'h0};
`endif

    // Table: each program runs to Halt with zero-wait memory.
    for (int k = 0; k < NV; k++) begin
      clear_mem();
      mem[0] = vecs[k].i0;  mem[1] = vecs[k].i1;  mem[2] = vecs[k].i2;  mem[3] = vecs[k].i3;
      mem[5] = vecs[k].d5;  mem[6] = vecs[k].d6;  mem[8] = vecs[k].d8;
      mem[12'hFFE] = vecs[k].dfe;  mem[12'hFFF] = vecs[k].dff;
      ack_delay = 0;
      do_reset();
      wait_halt(vecs[k].name, 200);
      repeat (10) @(negedge clk);
      check({vecs[k].name, "_ac"},      ac,               vecs[k].ac_exp);
      check({vecs[k].name, "_pc"},      pc,               vecs[k].pc_exp);
      check({vecs[k].name, "_illegal"}, illegal,          vecs[k].ill_exp);
      check({vecs[k].name, "_done"},    done_cnt,         vecs[k].done_exp);
      check({vecs[k].name, "_wr_cnt"},  wr_cnt,           vecs[k].wr_exp);
      check({vecs[k].name, "_wr_word"}, wr_word,          vecs[k].wr_word_exp);
      check({vecs[k].name, "_idle"},    req_while_halted, 0);
    end

    // Reset values and no request while in BOOT.
    clear_mem();
    mem[0] = 16'h9003;  mem[3] = 16'h7000;
    do_reset();
    check("boot_req", bus.mem_req, 0);
    check("reset_regs", {pc, ac, ir}, '0);
    check("reset_flags", {halted, illegal, instr_done}, 3'b000);

    // Zero-wait retire latencies, with stray acks that must be ignored outside requests.
    stray_ack = 1'b1;
    do_reset();
    cycles_to_done(30, n);
    check("lat_jump", n, 3);
    stray_ack = 1'b0;
    clear_mem();
    mem[0] = 16'h2007;
    do_reset();
    cycles_to_done(30, n);
    check("lat_store", n, 4);
    clear_mem();
    mem[0] = 16'h1005;  mem[5] = 16'h0007;
    do_reset();
    cycles_to_done(30, n);
    check("lat_load", n, 5);
`ifdef SEQ_INDIRECT_EN
    clear_mem();
    mem[0] = 16'hD005;  mem[5] = 16'h0008;  mem[8] = 16'h1234;
    do_reset();
    cycles_to_done(30, n);
    check("lat_loadi", n, 6);
`endif

    // Three wait cycles on each Load request: addr/we hold through the waits, retire at 10.
    clear_mem();
    mem[0] = 16'h1005;  mem[5] = 16'h0007;  mem[1] = 16'h7000;
    ack_delay = 3;
    do_reset();
    nreq = 0;
    cyc  = 0;
    while (nreq < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) begin
        check("wait_we_addr", {bus.mem_we, bus.mem_addr}, (nreq < 4) ? 13'h0000 : 13'h0005);
        nreq++;
      end
    end
    check("wait_req_cycles", nreq, 8);
    do_reset();
    cycles_to_done(60, n);
    check("lat_load_wait3", n, 11);
    @(negedge clk);
    check("wait_ac", ac, 16'h0007);

    // Reset while the second Load's operand read is pending.
    clear_mem();
    mem[0] = 16'h1005;  mem[1] = 16'h1006;  mem[5] = 16'h0007;  mem[6] = 16'h0009;
    ack_delay = 3;
    do_reset();
    cyc = 0;
    while (!(bus.mem_req && bus.mem_addr == 12'h006) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_read", {bus.mem_req, bus.mem_addr}, 13'h1006);
    check("pre_reset_ac", ac, 16'h0007);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_req", bus.mem_req, 0);
    check("mid_reset_regs", {pc, ac, ir}, '0);
    reset = 1'b0;
    cyc = 0;
    while (!bus.mem_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("refetch_addr", {bus.mem_req, bus.mem_we, bus.mem_addr}, 14'h2000);
    ack_delay = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
